// File: rtl/noc_ser_pkg.sv
// noc_ser_pkg: shared constants and types for the flit serializer front-end.
//   FLIT_W       flit width in bits
//   NUM_VC       number of virtual channels sharing the serializer
//   VC_W         width of an encoded VC index
//   CHUNK_W      serializer output chunk width
//   CHUNKS       chunks per flit
//   SER_DEPTH    serializer input FIFO entries (initial credit count)
//   DRAIN_CYCLES cycles the serializer needs per flit (chunks + one load cycle)
package noc_ser_pkg;

    localparam int unsigned FLIT_W       = 64;
    localparam int unsigned NUM_VC       = 4;
    localparam int unsigned VC_W         = $clog2(NUM_VC);
    localparam int unsigned CHUNK_W      = 4;
    localparam int unsigned CHUNKS       = FLIT_W / CHUNK_W;
    localparam int unsigned SER_DEPTH    = 2;
    localparam int unsigned DRAIN_CYCLES = CHUNKS + 1;

    typedef enum logic {
        StIdle,
        StLock
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority arbiter.
//   req  in   N      request vector
//   ptr  in   IDX_W  highest-priority index; priority falls off upward with wrap-around
//   gnt  out  N      one-hot grant, zero when no request
//   idx  out  IDX_W  encoded index of the grant (0 when no request)
// N must be a power of two so that the index addition wraps naturally.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    // Scan from the lowest priority to the highest so the last hit (closest to ptr) wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = ptr + IDX_W'(k);
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/ser_vc_scheduler.sv
// ser_vc_scheduler: shares one flit serializer between NUM_VC requesters, one wormhole
// packet at a time. Round-robin at packet boundaries, locked to the winner until its tail,
// with issue paced by a credit/drain model of the serializer's input FIFO.
//   clk        in   1              clock
//   rst_n      in   1              asynchronous active-low reset
//   en         in   1              low: no transfers, state held (drain timer keeps running)
//   req_valid  in   NUM_VC         per-VC flit available
//   req_flit   in   NUM_VC*FLIT_W  flattened flits, VC i at [i*FLIT_W +: FLIT_W]
//   req_tail   in   NUM_VC         flit is the last of its packet
//   req_ready  out  NUM_VC         combinational, one-hot or zero
//   ser_data   out  FLIT_W         registered flit to serializer
//   ser_valid  out  1              registered single-cycle valid pulse
//   ser_vc     out  log2(NUM_VC)   registered VC of ser_data
//   locked     out  1              a multi-flit packet is in progress
//   credits    out  log2(SER_DEPTH)+1  free serializer slots
module ser_vc_scheduler #(
    parameter int unsigned NUM_VC       = noc_ser_pkg::NUM_VC,
    parameter int unsigned FLIT_W       = noc_ser_pkg::FLIT_W,
    parameter int unsigned SER_DEPTH    = noc_ser_pkg::SER_DEPTH,
    parameter int unsigned DRAIN_CYCLES = noc_ser_pkg::DRAIN_CYCLES,
    localparam int unsigned VC_IDX_W    = $clog2(NUM_VC),
    localparam int unsigned CRED_W      = $clog2(SER_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_VC-1:0]        req_valid,
    input  logic [NUM_VC*FLIT_W-1:0] req_flit,
    input  logic [NUM_VC-1:0]        req_tail,
    output logic [NUM_VC-1:0]        req_ready,
    output logic [FLIT_W-1:0]        ser_data,
    output logic                     ser_valid,
    output logic [VC_IDX_W-1:0]      ser_vc,
    output logic                     locked,
    output logic [CRED_W-1:0]        credits
);

    import noc_ser_pkg::*;

    localparam int unsigned TMR_W = $clog2(DRAIN_CYCLES);

    sched_state_e          state_q, state_d;
    logic [VC_IDX_W-1:0]   lock_vc_q, lock_vc_d;
    logic [VC_IDX_W-1:0]   ptr_q, ptr_d;
    logic [CRED_W-1:0]     credits_q, credits_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [FLIT_W-1:0]     ser_data_q, ser_data_d;
    logic                  ser_valid_q, ser_valid_d;
    logic [VC_IDX_W-1:0]   ser_vc_q, ser_vc_d;

    logic [NUM_VC-1:0]     arb_gnt;
    logic [VC_IDX_W-1:0]   arb_idx;
    logic                  credit_ok;
    logic                  credits_full;
    logic                  credit_ret;
    logic                  xfer;
    logic [VC_IDX_W-1:0]   xfer_idx;

    rr_arbiter #(
        .N     (NUM_VC),
        .IDX_W (VC_IDX_W)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign credit_ok    = en && (credits_q != '0);
    assign credits_full = (credits_q == CRED_W'(SER_DEPTH));
    assign credit_ret   = !credits_full && (timer_q == TMR_W'(DRAIN_CYCLES - 1));

    // Grant and transfer decode.
    always_comb begin
        req_ready = '0;
        xfer_idx  = arb_idx;
        if (state_q == StLock) begin
            xfer_idx = lock_vc_q;
            if (credit_ok) begin
                req_ready[lock_vc_q] = req_valid[lock_vc_q];
            end
        end else if (credit_ok) begin
            req_ready = arb_gnt;
        end
        xfer = |(req_valid & req_ready);
    end

    // Packet lock FSM and round-robin pointer; the pointer only moves on a tail.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        ptr_d     = ptr_q;
        if (xfer) begin
            if (req_tail[xfer_idx]) begin
                state_d = StIdle;
                ptr_d   = xfer_idx + VC_IDX_W'(1);
            end else begin
                state_d   = StLock;
                lock_vc_d = xfer_idx;
            end
        end
    end

    // Credit accounting: a transfer and a drain return in the same cycle cancel out.
    always_comb begin
        credits_d = credits_q;
        if (xfer && !credit_ret) begin
            credits_d = credits_q - CRED_W'(1);
        end else if (!xfer && credit_ret) begin
            credits_d = credits_q + CRED_W'(1);
        end
        timer_d = (credits_full || credit_ret) ? '0 : timer_q + TMR_W'(1);
    end

    always_comb begin
        ser_valid_d = xfer;
        ser_data_d  = ser_data_q;
        ser_vc_d    = ser_vc_q;
        if (xfer) begin
            ser_data_d = req_flit[xfer_idx*FLIT_W +: FLIT_W];
            ser_vc_d   = xfer_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lock_vc_q   <= '0;
            ptr_q       <= '0;
            credits_q   <= CRED_W'(SER_DEPTH);
            timer_q     <= '0;
            ser_data_q  <= '0;
            ser_valid_q <= 1'b0;
            ser_vc_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_vc_q   <= lock_vc_d;
            ptr_q       <= ptr_d;
            credits_q   <= credits_d;
            timer_q     <= timer_d;
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            ser_vc_q    <= ser_vc_d;
        end
    end

    assign ser_data  = ser_data_q;
    assign ser_valid = ser_valid_q;
    assign ser_vc    = ser_vc_q;
    assign locked    = (state_q == StLock);
    assign credits   = credits_q;

endmodule

// File: tb/tb_ser_vc_scheduler.sv
// Bench for ser_vc_scheduler: directed scenarios plus randomized packet traffic, every
// cycle checked against a behavioural model of grants, credits and registered outputs.
module tb_ser_vc_scheduler;

    localparam int NV    = 4;
    localparam int FW    = 64;
    localparam int DEPTH = 2;
    localparam int DRAIN = 17;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [NV-1:0]     req_valid = '0;
    logic [NV*FW-1:0]  req_flit = '0;
    logic [NV-1:0]     req_tail = '0;
    logic [NV-1:0]     req_ready;
    logic [FW-1:0]     ser_data;
    logic              ser_valid;
    logic [1:0]        ser_vc;
    logic              locked;
    logic [1:0]        credits;

    ser_vc_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_flit  (req_flit),
        .req_tail  (req_tail),
        .req_ready (req_ready),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_vc    (ser_vc),
        .locked    (locked),
        .credits   (credits)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          m_cred, m_timer, m_ptr, m_vc, m_svc;
    bit          m_locked, m_sval;
    logic [FW-1:0] m_data;
    int          left[NV];     // flits remaining in the packet each VC is offering
    int          grants[$];    // VC of every transfer, in order

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cred = DEPTH; m_timer = 0; m_ptr = 0; m_vc = 0;
        m_locked = 0; m_sval = 0; m_data = '0; m_svc = 0;
    endtask

    // Which VC should transfer this cycle under the scheduling rules, or -1.
    function automatic int pick();
        if (!en || m_cred == 0) return -1;
        if (m_locked) return req_valid[m_vc] ? m_vc : -1;
        for (int k = 0; k < NV; k++) begin
            if (req_valid[(m_ptr + k) % NV]) return (m_ptr + k) % NV;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        chk("ser_valid", 64'(ser_valid), 64'(m_sval));
        chk("ser_data",  ser_data, m_data);
        chk("ser_vc",    64'(ser_vc), 64'(m_svc));
        chk("locked",    64'(locked), 64'(m_locked));
        chk("credits",   64'(credits), 64'(m_cred));
    endtask

    // One clock: drive traffic from left[], check ready, clock, advance model, check outputs.
    task automatic step(input bit bubbles, input bit fixed_flit);
        int            w;
        bit            ret, was_full;
        logic [NV-1:0] exp_r;
        for (int i = 0; i < NV; i++) begin
            req_valid[i] = (left[i] > 0) && (!bubbles || $urandom_range(0, 3) != 0);
            req_tail[i]  = (left[i] == 1);
            req_flit[i*FW +: FW] = fixed_flit ? {32'hDEAD_BEEF, 32'(i)} : {$urandom, $urandom};
        end
        #1;
        w = pick();
        exp_r = '0;
        if (w >= 0) exp_r[w] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_r));
        @(posedge clk);
        ret      = (m_cred < DEPTH) && (m_timer == DRAIN - 1);
        was_full = (m_cred == DEPTH);
        m_sval   = (w >= 0);
        if (w >= 0) begin
            m_cred = m_cred - 1;
            m_data = req_flit[w*FW +: FW];
            m_svc  = w;
            grants.push_back(w);
            if (req_tail[w]) begin
                m_locked = 0;
                m_ptr    = (w + 1) % NV;
            end else begin
                m_locked = 1;
                m_vc     = w;
            end
            left[w] = left[w] - 1;
        end
        if (ret) m_cred = m_cred + 1;
        m_timer = (was_full || ret) ? 0 : m_timer + 1;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NV; i++) left[i] = 0;
        req_valid = '0;
        #2;
        model_reset();
        check_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int sum;
        model_reset();
        for (int i = 0; i < NV; i++) left[i] = 0;
        en = 1'b1;
        #12;
        check_outputs();
        rst_n = 1'b1;

        // Single-flit packet on VC2, then watch the credit drain back.
        left[2] = 1;
        step(0, 1);
        chk("vc2_flit", ser_data, 64'hDEAD_BEEF_0000_0002);
        chk("vc2_vc", 64'(ser_vc), 64'd2);
        chk("vc2_credits", 64'(credits), 64'd1);
        for (int n = 0; n < 16; n++) step(0, 0);
        chk("drain_16", 64'(credits), 64'd1);
        step(0, 0);
        chk("drain_17", 64'(credits), 64'd2);

        // Two 3-flit packets contend; VC0 wins and holds the lock.
        do_reset();
        grants.delete();
        left[0] = 3; left[3] = 3;
        guard = 0;
        while ((left[0] + left[3]) > 0 && guard < 300) begin
            step(0, 0);
            guard++;
        end
        chk("pkts_done", 64'(left[0] + left[3]), 64'd0);
        for (int k = 0; k < 6 && k < grants.size(); k++)
            chk("pkt_order", 64'(grants[k]), (k < 3) ? 64'd0 : 64'd3);

        // Continuous stream on VC1 exercises zero-credit stalls.
        left[1] = 1000;
        for (int n = 0; n < 60; n++) step(0, 0);
        left[1] = 0;
        for (int n = 0; n < 40; n++) step(0, 0);

        // Transfer landing exactly on a credit return.
        do_reset();
        left[0] = 1;
        step(0, 0);
        guard = 0;
        while (m_timer != DRAIN - 1 && guard < 40) begin
            step(0, 0);
            guard++;
        end
        chk("coincide_reached", 64'(guard < 40), 64'd1);
        left[0] = 1;
        step(0, 0);
        chk("coincide_valid", 64'(ser_valid), 64'd1);
        chk("coincide_credits", 64'(credits), 64'd1);
        for (int n = 0; n < 16; n++) step(0, 0);
        chk("restart_16", 64'(credits), 64'd1);
        step(0, 0);
        chk("restart_17", 64'(credits), 64'd2);

        // All VCs offer single-flit packets: strict rotation.
        do_reset();
        grants.delete();
        guard = 0;
        while (grants.size() < 8 && guard < 400) begin
            for (int i = 0; i < NV; i++) if (left[i] == 0) left[i] = 1;
            step(0, 0);
            guard++;
        end
        chk("rotation_done", 64'(grants.size() >= 8), 64'd1);
        for (int k = 0; k < 8 && k < grants.size(); k++)
            chk("rotation", 64'(grants[k]), 64'(k % NV));

        // Reset in the middle of a VC1 packet; VC2 must win afterwards.
        do_reset();
        left[1] = 4;
        step(0, 0);
        chk("mid_locked", 64'(locked), 64'd1);
        do_reset();
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_credits", 64'(credits), 64'd2);
        left[2] = 1;
        step(0, 0);
        chk("post_rst_vc", 64'(ser_vc), 64'd2);

        // Randomized packets with bubbles and en toggling.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NV; i++)
                if (left[i] == 0 && $urandom_range(0, 2) == 0) left[i] = $urandom_range(1, 4);
            en = ($urandom_range(0, 7) != 0);
            step(1, 0);
        end
        en = 1'b1;
        sum = 0;
        guard = 0;
        do begin
            sum = 0;
            for (int i = 0; i < NV; i++) sum += left[i];
            if (sum > 0) step(0, 0);
            guard++;
        end while (sum > 0 && guard < 2000);
        chk("random_drained", 64'(sum), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
